// File: rtl/flag_register_branch_unit.sv
// -----------------------------------------------------------------------------
// flag_register_branch_unit
//
// Sits behind the ALU flag indicator. Holds the architectural Z/C/N status
// register, a small LIFO so flags can be saved across calls/interrupts, and a
// three-state branch resolver that reports taken/not-taken plus the next PC.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   Flags_in[2:0]   combinational flags from the indicator ([0]=Z [1]=C [2]=N)
//   flag_we         latch Flags_in at the next edge
//   push_flags      save Flags_out onto the stack
//   pop_flags       restore top of stack into the flag register
//   err_clr         clear sticky stack_err
//   br_req          branch resolve request (pulse, dropped while busy)
//   br_cond[2:0]    condition code
//   br_target[N-1:0], pc_next[N-1:0]  taken / fall-through PCs
//   Flags_out[2:0]  registered flags
//   br_busy         resolver not idle
//   br_valid        one-cycle pulse, br_taken/pc_out valid
//   br_taken, pc_out[N-1:0]  resolved branch (held outside br_valid)
//   stack_full, stack_empty, stack_err  stack status
// -----------------------------------------------------------------------------
module flag_register_branch_unit #(
    parameter int unsigned N           = 8,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   Flags_in,
    input  logic         flag_we,
    input  logic         push_flags,
    input  logic         pop_flags,
    input  logic         err_clr,
    input  logic         br_req,
    input  logic [2:0]   br_cond,
    input  logic [N-1:0] br_target,
    input  logic [N-1:0] pc_next,
    output logic [2:0]   Flags_out,
    output logic         br_busy,
    output logic         br_valid,
    output logic         br_taken,
    output logic [N-1:0] pc_out,
    output logic         stack_full,
    output logic         stack_empty,
    output logic         stack_err
);

    localparam int unsigned IdxW = $clog2(STACK_DEPTH);
    // One extra bit so "full" is distinguishable from "empty" without wrap.
    localparam int unsigned PtrW = IdxW + 1;
    localparam logic [PtrW-1:0] FullCount = PtrW'(STACK_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StResp
    } brState_e;

    brState_e        stateQ, stateD;
    logic [2:0]      flagsQ, flagsD;
    logic [PtrW-1:0] ptrQ, ptrD, topPtr;
    logic            errQ, errD;
    logic [2:0]      stackMem [STACK_DEPTH];

    logic [2:0]      condQ;
    logic [N-1:0]    targetQ, pcNextQ;
    logic            takenQ;
    logic [N-1:0]    pcOutQ;
    logic            condTrue;

    logic pushOnly, popOnly, doPush, doPop, stackFault;

    // ---------------------------------------------------------------- stack
    assign stack_full  = (ptrQ == FullCount);
    assign stack_empty = (ptrQ == '0);
    assign topPtr      = ptrQ - PtrW'(1);

    // Simultaneous push and pop cancel each other without raising an error.
    assign pushOnly   = push_flags & ~pop_flags;
    assign popOnly    = pop_flags & ~push_flags;
    assign doPush     = pushOnly & ~stack_full;
    assign doPop      = popOnly & ~stack_empty;
    assign stackFault = (pushOnly & stack_full) | (popOnly & stack_empty);

    always_comb begin
        flagsD = flagsQ;
        if (doPop) begin
            flagsD = stackMem[topPtr[IdxW-1:0]];
        end else if (flag_we) begin
            flagsD = Flags_in;
        end
    end

    always_comb begin
        ptrD = ptrQ;
        if (doPush) begin
            ptrD = ptrQ + PtrW'(1);
        end else if (doPop) begin
            ptrD = topPtr;
        end
    end

    // A new fault in the same cycle as err_clr keeps the flag set.
    always_comb begin
        errD = errQ;
        if (stackFault) begin
            errD = 1'b1;
        end else if (err_clr) begin
            errD = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flagsQ <= 3'b000;
            ptrQ   <= '0;
            errQ   <= 1'b0;
        end else begin
            flagsQ <= flagsD;
            ptrQ   <= ptrD;
            errQ   <= errD;
        end
    end

    // Storage only; validity is tracked by ptrQ, so no reset is needed.
    always_ff @(posedge clk) begin
        if (doPush) begin
            stackMem[ptrQ[IdxW-1:0]] <= flagsQ;
        end
    end

    assign Flags_out = flagsQ;
    assign stack_err = errQ;

    // --------------------------------------------------------- branch unit
    // Evaluated in EVAL against the flag register as it stands then, so a
    // flag write or pop in the request cycle is already visible.
    always_comb begin
        condTrue = 1'b0;
        case (condQ)
            3'b000:  condTrue = 1'b1;
            3'b001:  condTrue = flagsQ[0];
            3'b010:  condTrue = ~flagsQ[0];
            3'b011:  condTrue = flagsQ[1];
            3'b100:  condTrue = ~flagsQ[1];
            3'b101:  condTrue = flagsQ[2];
            3'b110:  condTrue = ~flagsQ[2];
            default: condTrue = 1'b0;
        endcase
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle:  if (br_req) stateD = StEval;
            StEval:  stateD = StResp;
            StResp:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            condQ   <= 3'b000;
            targetQ <= '0;
            pcNextQ <= '0;
            takenQ  <= 1'b0;
            pcOutQ  <= '0;
        end else begin
            if (stateQ == StIdle && br_req) begin
                condQ   <= br_cond;
                targetQ <= br_target;
                pcNextQ <= pc_next;
            end
            if (stateQ == StEval) begin
                takenQ <= condTrue;
                pcOutQ <= condTrue ? targetQ : pcNextQ;
            end
        end
    end

    assign br_busy  = (stateQ != StIdle);
    assign br_valid = (stateQ == StResp);
    assign br_taken = takenQ;
    assign pc_out   = pcOutQ;

endmodule

// File: tb/tb_flag_register_branch_unit.sv
module tb_flag_register_branch_unit;

    localparam int N = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [2:0]   Flags_in = '0;
    logic         flag_we = 0, push_flags = 0, pop_flags = 0, err_clr = 0, br_req = 0;
    logic [2:0]   br_cond = '0;
    logic [N-1:0] br_target = '0, pc_next = '0;
    logic [2:0]   Flags_out;
    logic         br_busy, br_valid, br_taken, stack_full, stack_empty, stack_err;
    logic [N-1:0] pc_out;

    flag_register_branch_unit #(.N(N), .STACK_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .Flags_in(Flags_in), .flag_we(flag_we),
        .push_flags(push_flags), .pop_flags(pop_flags), .err_clr(err_clr),
        .br_req(br_req), .br_cond(br_cond), .br_target(br_target), .pc_next(pc_next),
        .Flags_out(Flags_out), .br_busy(br_busy), .br_valid(br_valid),
        .br_taken(br_taken), .pc_out(pc_out), .stack_full(stack_full),
        .stack_empty(stack_empty), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         taken;
        logic [N-1:0] pc;
    } exp_t;

    // Reference model state
    logic [2:0]   mFlags;
    logic [2:0]   mStack[$];
    logic         mErr;
    int           mCnt;          // cycles until resolver back in idle
    exp_t         mPend, mLast;
    exp_t         sbq[$];

    int checks = 0;
    int errors = 0;
    bit done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic condHolds(input logic [2:0] f, input logic [2:0] c);
        logic z, cy, n;
        z = f[0]; cy = f[1]; n = f[2];
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return cy;
            3'd4: return !cy;
            3'd5: return n;
            3'd6: return !n;
            default: return 1'b0;
        endcase
    endfunction

    task automatic modelReset();
        mFlags = 3'b000;
        mStack.delete();
        mErr = 1'b0;
        mCnt = 0;
        mLast = '0;
        mPend = '0;
        sbq.delete();
    endtask

    // Apply one clock edge worth of architectural behaviour.
    task automatic modelEdge();
        logic [2:0] nf;
        bit fault, popped;
        nf = mFlags; fault = 0; popped = 0;
        if (push_flags && !pop_flags) begin
            if (mStack.size() == D) fault = 1;
            else mStack.push_back(mFlags);
        end
        if (pop_flags && !push_flags) begin
            if (mStack.size() == 0) fault = 1;
            else begin
                nf = mStack.pop_back();
                popped = 1;
            end
        end
        if (!popped && flag_we) nf = Flags_in;
        mFlags = nf;
        if (fault) mErr = 1'b1;
        else if (err_clr) mErr = 1'b0;

        if (mCnt == 0) begin
            if (br_req) begin
                // Condition sees the flags as updated by this same edge.
                mPend.taken = condHolds(mFlags, br_cond);
                mPend.pc    = mPend.taken ? br_target : pc_next;
                sbq.push_back(mPend);
                mCnt = 2;
            end
        end else begin
            mCnt--;
            if (mCnt == 1) mLast = mPend;
        end
    endtask

    task automatic clearInputs();
        flag_we = 0; push_flags = 0; pop_flags = 0; err_clr = 0; br_req = 0;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) modelEdge();
        #2;
        clearInputs();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        modelReset();
        #1;
        chk("rst_flags", Flags_out, 0);
        chk("rst_busy", br_busy, 0);
        chk("rst_valid", br_valid, 0);
        chk("rst_taken", br_taken, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_err", stack_err, 0);
        chk("rst_empty", stack_empty, 1);
        chk("rst_full", stack_full, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            chk("flags", Flags_out, mFlags);
            chk("full", stack_full, mStack.size() == D);
            chk("empty", stack_empty, mStack.size() == 0);
            chk("err", stack_err, mErr);
            chk("busy", br_busy, mCnt != 0);
            chk("valid", br_valid, mCnt == 1);
            chk("taken_hold", br_taken, mLast.taken);
            chk("pc_hold", pc_out, mLast.pc);
            if (br_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid actual=1 expected=0 t=%0t", $time);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_taken", br_taken, e.taken);
                    chk("sb_pc", pc_out, e.pc);
                end
            end
        end
    end

    initial begin
        modelReset();
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Taken branch on Z
        flag_we = 1; Flags_in = 3'b001; step();
        br_req = 1; br_cond = 3'b001; br_target = 8'h40; pc_next = 8'h11; step();
        step();
        chk("t2_valid", br_valid, 1);
        chk("t2_taken", br_taken, 1);
        chk("t2_pc", pc_out, 8'h40);
        step(); step();

        // Flag write in request cycle is seen; requests while busy dropped
        flag_we = 1; Flags_in = 3'b000;
        br_req = 1; br_cond = 3'b001; br_target = 8'h55; pc_next = 8'h22; step();
        br_req = 1; step();
        chk("t3_valid", br_valid, 1);
        chk("t3_taken", br_taken, 0);
        chk("t3_pc", pc_out, 8'h22);
        br_req = 1; step();
        step();
        chk("t3_nopulse", br_valid, 0);
        chk("t3_idle", br_busy, 0);

        // Save / restore
        flag_we = 1; Flags_in = 3'b110; step();
        push_flags = 1; step();
        flag_we = 1; Flags_in = 3'b001; step();
        pop_flags = 1; step();
        chk("t4_flags", Flags_out, 3'b110);
        chk("t4_empty", stack_empty, 1);
        chk("t4_err", stack_err, 0);

        // Overflow / underflow
        for (int i = 0; i < 4; i++) begin
            push_flags = 1; step();
        end
        chk("t5_full", stack_full, 1);
        chk("t5_noerr", stack_err, 0);
        push_flags = 1; step();
        chk("t5_ovf", stack_err, 1);
        err_clr = 1; step();
        chk("t5_clr", stack_err, 0);
        for (int i = 0; i < 4; i++) begin
            pop_flags = 1; step();
        end
        pop_flags = 1; step();
        chk("t5_unf", stack_err, 1);
        chk("t5_flags", Flags_out, 3'b110);

        // Push and pop together
        err_clr = 1; step();
        push_flags = 1; pop_flags = 1; flag_we = 1; Flags_in = 3'b100; step();
        chk("t6_flags", Flags_out, 3'b100);
        chk("t6_err", stack_err, 0);
        chk("t6_empty", stack_empty, 1);

        // Reset while resolving: no pulse afterwards
        br_req = 1; br_cond = 3'b000; step();
        doReset();
        repeat (4) step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            Flags_in   = 3'($urandom);
            flag_we    = 1'($urandom % 2);
            push_flags = ($urandom % 4) == 0;
            pop_flags  = ($urandom % 4) == 0;
            err_clr    = ($urandom % 8) == 0;
            br_req     = ($urandom % 3) == 0;
            br_cond    = 3'($urandom);
            br_target  = 8'($urandom);
            pc_next    = 8'($urandom);
            step();
            if ($urandom % 250 == 0) doReset();
        end

        repeat (5) step();
        chk("sb_drain", sbq.size(), 0);
        done = 1;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
